// File: rtl/conv_seq_ctrl_pkg.sv
// conv_ctrl_pkg: shared state encoding and default tap geometry for the convolution sequencer
package conv_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, BIAS, DONE} state_t;
  localparam int SIZE_D = 7;
  localparam int T = SIZE_D * SIZE_D;
  localparam int IDX_W = $clog2(T);
endpackage

// File: rtl/conv_seq_ctrl_if.sv
// conv_seq_ctrl_if: start/result handshakes and tap-buffer read port of the convolution sequencer
interface conv_seq_ctrl_if
  import conv_ctrl_pkg::*;
#(
  parameter int N = 32,
  parameter int AW = IDX_W
);
  logic start, start_ready, abort;
  logic [N-1:0] bias;
  logic tap_rd_en;
  logic [AW-1:0] tap_addr;
  logic [N-1:0] filter_rdata, input_rdata;
  logic out_valid, out_ready;
  logic [N-1:0] conv_output;
  logic busy;
  modport master (
    output start, abort, bias, filter_rdata, input_rdata, out_ready,
    input start_ready, tap_rd_en, tap_addr, out_valid, conv_output, busy
  );
  modport slave (
    input start, abort, bias, filter_rdata, input_rdata, out_ready,
    output start_ready, tap_rd_en, tap_addr, out_valid, conv_output, busy
  );
endinterface

// File: rtl/conv_seq_ctrl_arith.sv
// fma / qadd: combinational fixed-point units; two's-complement wrap, product truncated toward -inf
module fma #(
  parameter int QN = 15,
  parameter int N = 32
) (
  input  logic [N-1:0] acc,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);
  logic signed [2*N-1:0] p;
  assign p = $signed(a) * $signed(b);
  assign y = acc + N'(p >>> QN);
endmodule

module qadd #(
  parameter int QN = 15,
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/conv_seq_ctrl_tap_counter.sv
// tap_counter: tap index with clear, enable and terminal flag; holds at the last tap
module tap_counter #(
  parameter int W = 6,
  parameter int LAST = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] idx,
  output logic         last
);
  assign last = idx == W'(LAST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idx <= '0;
    else if (clr) idx <= '0;
    else if (en && !last) idx <= idx + 1'b1;
endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequences T tap reads, accumulates filter*input, adds bias and presents the result
module conv_seq_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int SIZE = SIZE_D,
  parameter int QN = 15,
  parameter int N = 32
) (
  input logic clk,
  input logic rst_n,
  conv_seq_ctrl_if.slave bus
);
  localparam int TC = SIZE * SIZE;
  localparam int AW = $clog2(TC);
  state_t state, nxt;
  logic [AW-1:0] idx;
  logic last, rd_q, accept, run;
  logic [N-1:0] acc, bias_q, fma_y, sum;
  assign run = state == RUN;
  assign accept = state == IDLE && bus.start && !bus.abort;
  assign bus.start_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.tap_rd_en = run;
  assign bus.tap_addr = run ? idx : '0;
  assign bus.out_valid = state == DONE;
  tap_counter #(.W(AW), .LAST(TC - 1)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr(accept), .en(run), .idx(idx), .last(last)
  );
  fma #(.QN(QN), .N(N)) u_fma (
    .acc(acc), .a(bus.filter_rdata), .b(bus.input_rdata), .y(fma_y)
  );
  qadd #(.QN(QN), .N(N)) u_qadd (.a(acc), .b(bias_q), .y(sum));
  always_comb begin
    nxt = state;
    nxt = (state != IDLE && bus.abort) ? IDLE :
          state == IDLE  ? (accept ? RUN : IDLE) :
          state == RUN   ? (last ? DRAIN : RUN) :
          state == DRAIN ? BIAS :
          state == BIAS  ? DONE :
          (bus.out_ready ? IDLE : DONE);
  end
  // read data lags the strobe by one cycle, so accumulation follows rd_q
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rd_q <= 1'b0;
      acc <= '0;
      bias_q <= '0;
      bus.conv_output <= '0;
    end else begin
      state <= nxt;
      rd_q <= run && !bus.abort;
      if (accept) begin
        acc <= '0;
        bias_q <= bus.bias;
      end else if (rd_q) acc <= fma_y;
      if (state == BIAS && !bus.abort) bus.conv_output <= sum;
    end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: vector table plus corner sequences against a fixed-point scoreboard
module tb_conv_seq_ctrl;
  import conv_ctrl_pkg::*;
  typedef struct {
    int kind;
    logic [31:0] bias;
    logic [31:0] exp;
  } vec_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  conv_seq_ctrl_if #(.N(32), .AW(6)) bus ();
  conv_seq_ctrl #(.SIZE(7), .QN(15), .N(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [31:0] filt[49], inp[49];
  logic [31:0] exp_q[$];
  vec_t vecs[4];
  int n_cmp = 0, n_bad = 0;
  always @(posedge clk)
    if (bus.tap_rd_en) begin
      bus.filter_rdata <= filt[bus.tap_addr];
      bus.input_rdata <= inp[bus.tap_addr];
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  task automatic load(input int kind);
    for (int i = 0; i < 49; i++) begin
      case (kind)
        0: begin filt[i] = 32'h8000; inp[i] = 32'h8000; end
        1: begin filt[i] = (i == 48) ? 32'h8000 : 32'h0; inp[i] = (i == 48) ? 32'h10000 : 32'h7fff0000; end
        2: begin filt[i] = 32'hffffc000; inp[i] = 32'(i) << 15; end
        default: begin filt[i] = 32'(i * 32'h0135_79bd) ^ 32'h5a5a_1234; inp[i] = 32'(i * 32'h00f1_3377) + 32'h8765_4321; end
      endcase
    end
  endtask
  function automatic logic [31:0] model(input logic [31:0] b);
    logic signed [63:0] p;
    logic [31:0] a;
    a = 0;
    for (int i = 0; i < 49; i++) begin
      p = $signed(filt[i]) * $signed(inp[i]);
      a = a + p[46:15];
    end
    return a + b;
  endfunction
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!bus.out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic finish_op(input string name);
    if (!bus.out_valid || exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: out_valid=%b queued=%0d", name, bus.out_valid, exp_q.size());
    end else chk(name, bus.conv_output, exp_q.pop_front());
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
  endtask
  task automatic run_op(input string name, input logic [31:0] b, input logic [31:0] e);
    int cyc;
    exp_q.push_back(e);
    bus.bias = b;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    wait_valid(cyc);
    chk({name, "_lat"}, 32'(cyc), 32'd52);
    finish_op(name);
  endtask
  task automatic start_only();
    bus.bias = 0;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
  endtask
  task automatic no_valid(input string name);
    logic seen;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk(name, 32'(seen), 32'd0);
  endtask
  initial begin
    int cyc;
    logic [31:0] hold;
    bus.start = 0; bus.abort = 0; bus.bias = 0; bus.out_ready = 0;
    vecs[0] = '{0, 32'h0, 32'h00188000};
    vecs[1] = '{1, 32'h4000, 32'h00014000};
    load(2); vecs[2] = '{2, 32'h0001_2000, model(32'h0001_2000)};
    load(3); vecs[3] = '{3, 32'hdead_beef, model(32'hdead_beef)};
    repeat (2) @(negedge clk);
    chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_rd_en", 32'(bus.tap_rd_en), 32'd0);
    chk("rst_addr", 32'(bus.tap_addr), 32'd0);
    chk("rst_conv_output", bus.conv_output, 32'd0);
    rst_n = 1;
    @(negedge clk);
    for (int v = 0; v < 4; v++) begin
      load(vecs[v].kind);
      run_op($sformatf("vec%0d", v), vecs[v].bias, vecs[v].exp);
    end
    // result held while the consumer stalls; a start in DONE is ignored
    load(0);
    exp_q.push_back(32'h00188000);
    start_only();
    wait_valid(cyc);
    hold = bus.conv_output;
    chk("stall_value", hold, 32'h00188000);
    for (int k = 0; k < 10; k++) begin
      bus.start = (k == 4);
      @(negedge clk);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_hold", bus.conv_output, hold);
      chk("stall_start_ready", 32'(bus.start_ready), 32'd0);
    end
    bus.start = 0;
    finish_op("stall_result");
    chk("post_done_ready", 32'(bus.start_ready), 32'd1);
    chk("post_done_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("post_done_busy", 32'(bus.busy), 32'd0);
    // abort in IDLE beats start
    bus.start = 1; bus.abort = 1;
    @(negedge clk);
    bus.start = 0; bus.abort = 0;
    chk("abort_wins_idle", 32'(bus.start_ready), 32'd1);
    // abort mid-RUN drops the operation
    start_only();
    repeat (19) @(negedge clk);
    chk("abort_in_run", 32'(bus.tap_rd_en), 32'd1);
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    chk("abort_ready", 32'(bus.start_ready), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rd_en", 32'(bus.tap_rd_en), 32'd0);
    no_valid("abort_no_valid");
    run_op("after_abort", 32'h0, 32'h00188000);
    // asynchronous reset mid-RUN
    start_only();
    repeat (20) @(negedge clk);
    rst_n = 0;
    #1;
    chk("arst_ready", 32'(bus.start_ready), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_rd_en", 32'(bus.tap_rd_en), 32'd0);
    chk("arst_addr", 32'(bus.tap_addr), 32'd0);
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_output", bus.conv_output, 32'd0);
    @(negedge clk);
    rst_n = 1;
    no_valid("arst_no_valid");
    run_op("after_reset", 32'h0, 32'h00188000);
    // back-to-back with out_ready tied high and start held
    exp_q.push_back(32'h00188000);
    exp_q.push_back(32'h0018c000);
    bus.out_ready = 1;
    bus.bias = 0;
    bus.start = 1;
    @(negedge clk);
    bus.bias = 32'h4000;
    wait_valid(cyc);
    chk("b2b_first", bus.conv_output, exp_q.size() > 0 ? exp_q.pop_front() : 32'hx);
    @(negedge clk);
    chk("b2b_idle_after_done", 32'(bus.start_ready), 32'd1);
    @(negedge clk);
    bus.start = 0;
    chk("b2b_accept_rd_en", 32'(bus.tap_rd_en), 32'd1);
    chk("b2b_accept_addr", 32'(bus.tap_addr), 32'd0);
    wait_valid(cyc);
    chk("b2b_lat", 32'(cyc), 32'd52);
    chk("b2b_second", bus.conv_output, exp_q.size() > 0 ? exp_q.pop_front() : 32'hx);
    @(negedge clk);
    bus.out_ready = 0;
    chk("b2b_end_valid", 32'(bus.out_valid), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
